// File: rtl/cpu_pkg.sv
// Shared core constants used by the fetch front end, controller and datapath.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h1000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} pairs; clr overrides push/pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             clr,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wptr_q] <= wdata;
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/rv32i_fetch_buffer.sv
// Instruction fetch front end: credit-limited word fetches into a {pc, instr} queue
// presented to Decode under a stall/valid handshake, flushed by redirects.
module rv32i_fetch_buffer #(
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [XLEN-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR,
    localparam int unsigned     CW        = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            n_rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_d,
    output logic            valid_d,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [CW-1:0]   count
);

    localparam int unsigned UW = CW + 1;

    logic [XLEN-1:0]   fpc_q, fpc_d;
    logic              infl_q, infl_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              discard_q, discard_d;

    logic              push, pop;
    logic [2*XLEN-1:0] head;
    logic [UW-1:0]     used;

    // Entries held plus the one in flight must stay below DEPTH before a new fetch.
    assign used      = {1'b0, count} + UW'(infl_q);
    assign imem_req  = n_rst && !redirect && (used < UW'(DEPTH));
    assign imem_addr = fpc_q;

    assign push = infl_q && !discard_q && !redirect;
    assign pop  = valid_d && !stall_d && !redirect;

    always_comb begin
        fpc_d     = fpc_q;
        infl_d    = 1'b0;
        addr_d    = addr_q;
        discard_d = redirect;
        if (redirect) begin
            fpc_d = redirect_pc & ~XLEN'(3);
        end else if (imem_req) begin
            fpc_d  = fpc_q + XLEN'(4);
            infl_d = 1'b1;
            addr_d = fpc_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            addr_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            fpc_q     <= fpc_d;
            infl_q    <= infl_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .wdata ({addr_q, imem_rdata}),
        .pop   (pop),
        .clr   (redirect),
        .head  (head),
        .count (count)
    );

    assign valid_d = (count != '0);
    assign pc_d    = valid_d ? head[2*XLEN-1:XLEN] : '0;
    assign instr_d = valid_d ? head[XLEN-1:0] : NOP_INSTR;

endmodule

// File: tb/tb_rv32i_fetch_buffer.sv
// Self-checking bench for rv32i_fetch_buffer: a monitor scoreboards every fetch
// against every instruction Decode consumes, while scenario tasks check timing.
module tb_rv32i_fetch_buffer;

    localparam logic [31:0] K      = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC = 32'h1000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall_d = 1'b0;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [2:0]  count;

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    rv32i_fetch_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_d     (stall_d),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .count       (count)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous memory
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;

    // Scoreboard monitor: fetches pushed in issue order, popped on consumption.
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (!valid_d) begin
                checks++;
                if (instr_d !== NOP || pc_d !== 32'h0) begin
                    failures++;
                    $display("FAIL idle_out instr_d=%h pc_d=%h required %h/00000000",
                             instr_d, pc_d, NOP);
                end
            end
            if (redirect) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL redirect_noreq imem_req=%b required 0", imem_req);
                end
                exp_q.delete();
                exp_fetch = redirect_pc & ~32'h3;
            end else begin
                if (valid_d && !stall_d) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_instr pc_d=%h required none", pc_d);
                    end else begin
                        e = exp_q.pop_front();
                        if (pc_d !== e || instr_d !== (e ^ K)) begin
                            failures++;
                            $display("FAIL order pc_d=%h instr_d=%h required %h/%h",
                                     pc_d, instr_d, e, e ^ K);
                        end
                    end
                end
                if (imem_req === 1'b1) begin
                    checks++;
                    if (imem_addr !== exp_fetch) begin
                        failures++;
                        $display("FAIL fetch_addr imem_addr=%h required %h", imem_addr, exp_fetch);
                    end
                    exp_q.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 32'h4;
                end
            end
        end
    end

    task automatic test_reset();
        logic [100:0] got;
        @(negedge clk);
        #1;
        got = {imem_req, imem_addr, valid_d, instr_d, pc_d, count};
        checks++;
        if (got !== {1'b0, RST_PC, 1'b0, NOP, 32'h0, 3'd0}) begin
            failures++;
            $display("FAIL reset_values got=%h required %h", got,
                     {1'b0, RST_PC, 1'b0, NOP, 32'h0, 3'd0});
        end
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        exp_fetch = RST_PC;
        mon_en = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_req req=%b addr=%h required 1/%h", imem_req, imem_addr, RST_PC);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b0) begin
            failures++;
            $display("FAIL latency_c1 valid_d=%b required 0", valid_d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b1 || pc_d !== RST_PC) begin
            failures++;
            $display("FAIL latency_c2 valid_d=%b pc_d=%h required 1/%h", valid_d, pc_d, RST_PC);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (valid_d !== 1'b1 || count !== 3'd1) begin
                failures++;
                $display("FAIL throughput valid_d=%b count=%0d required 1/1", valid_d, count);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [2:0]  exp_cnt;
        held = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stall_d = 1'b1;
            #1;
            if (i == 0) held = instr_d;
            exp_cnt = (i < 3) ? 3'(i + 1) : 3'd4;
            checks++;
            if (count !== exp_cnt || imem_req !== (i < 2) || instr_d !== held) begin
                failures++;
                $display("FAIL stall_%0d count=%0d req=%b instr=%h required %0d/%b/%h",
                         i, count, imem_req, instr_d, exp_cnt, (i < 2), held);
            end
        end
        @(negedge clk);
        stall_d = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume valid_d=%b required 1", valid_d);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0300 || valid_d !== 1'b0) begin
            failures++;
            $display("FAIL b2b_req req=%b addr=%h valid=%b required 1/00000300/0",
                     imem_req, imem_addr, valid_d);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b1 || pc_d !== 32'h0000_0300) begin
            failures++;
            $display("FAIL b2b_first valid=%b pc_d=%h required 1/00000300", valid_d, pc_d);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_redirect();
        @(negedge clk);
        stall_d = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre count=%0d required 3", count);
        end
        @(negedge clk);
        redirect = 1'b0;
        stall_d = 1'b0;
        #1;
        checks++;
        if (valid_d !== 1'b0 || count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL flush_r1 valid=%b count=%0d req=%b addr=%h required 0/0/1/00000100",
                     valid_d, count, imem_req, imem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b0) begin
            failures++;
            $display("FAIL flush_r2 valid=%b required 0", valid_d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b1 || pc_d !== 32'h0000_0100) begin
            failures++;
            $display("FAIL flush_r3 valid=%b pc_d=%h required 1/00000100", valid_d, pc_d);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_align req=%b addr=%h required 1/fffffffc", imem_req, imem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_next req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b1 || pc_d !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_pc valid=%b pc_d=%h required 1/00000000", valid_d, pc_d);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [100:0] got;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stall_d = 1'b1;
        end
        #1;
        checks++;
        if (count !== 3'd4 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL full_pre count=%0d req=%b required 4/0", count, imem_req);
        end
        #1;
        mon_en = 1'b0;
        n_rst = 1'b0;
        #1;
        got = {imem_req, imem_addr, valid_d, instr_d, pc_d, count};
        checks++;
        if (got !== {1'b0, RST_PC, 1'b0, NOP, 32'h0, 3'd0}) begin
            failures++;
            $display("FAIL async_reset got=%h required %h", got,
                     {1'b0, RST_PC, 1'b0, NOP, 32'h0, 3'd0});
        end
        @(negedge clk);
        stall_d = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        exp_fetch = RST_PC;
        mon_en = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL restart_req req=%b addr=%h required 1/%h", imem_req, imem_addr, RST_PC);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (valid_d !== 1'b1 || pc_d !== RST_PC) begin
            failures++;
            $display("FAIL restart_pc valid=%b pc_d=%h required 1/%h", valid_d, pc_d, RST_PC);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_reset_mid();
        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
